// File: rtl/program_loader_pkg.sv
// -----------------------------------------------------------------------------
// program_loader_pkg
//   Shared definitions for the instruction-cache download path. The icache and
//   the loader both import the geometry defaults, so the two always agree on
//   the number of cells and the address width.
//   Contents:
//     DEFAULT_DEPTH      number of 16-bit icache cells (max instruction count)
//     DEFAULT_ADDR_W     width of the icache write address
//     DEFAULT_SYNC_BYTE  frame start marker
//     loader_state_t     loader FSM state encoding
//     is_idle_like()     true for the states that accept a start pulse
// -----------------------------------------------------------------------------
package program_loader_pkg;

    localparam int         DEFAULT_DEPTH     = 1000;
    localparam int         DEFAULT_ADDR_W    = 10;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_SYNC    = 4'd1,
        ST_LEN_HI  = 4'd2,
        ST_LEN_LO  = 4'd3,
        ST_DATA_HI = 4'd4,
        ST_DATA_LO = 4'd5,
        ST_CHK     = 4'd6,
        ST_DONE    = 4'd7,
        ST_ERROR   = 4'd8
    } loader_state_t;

    // States in which the loader is not consuming a frame and a start pulse
    // (re)arms it.
    function automatic logic is_idle_like(input loader_state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/program_loader_halfword_assembler.sv
// -----------------------------------------------------------------------------
// halfword_assembler
//   Byte-to-halfword datapath of the program loader. Latches the high byte of
//   an instruction, joins it with the low byte into a big-endian 16-bit word
//   and emits that word with a single-cycle word_valid one cycle after the
//   low byte is accepted. Also keeps the running XOR checksum of the frame.
//   Ports:
//     clk         system clock
//     rst         synchronous, active-high reset
//     clear       start of a new frame: zero high byte and checksum
//     byte_valid  byte_data is valid this cycle
//     byte_data   received byte
//     load_hi     current byte is an instruction high byte
//     load_lo     current byte is an instruction low byte (emit word)
//     accumulate  current byte contributes to the checksum
//     word_valid  1-cycle pulse, word holds a complete instruction
//     word        assembled instruction {hi, lo}
//     checksum    XOR of all accumulated bytes so far
// -----------------------------------------------------------------------------
module halfword_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        load_hi,
    input  logic        load_lo,
    input  logic        accumulate,
    output logic        word_valid,
    output logic [15:0] word,
    output logic [7:0]  checksum
);

    logic [7:0]  hi_q,         hi_d;
    logic [15:0] word_q,       word_d;
    logic        word_valid_q, word_valid_d;
    logic [7:0]  checksum_q,   checksum_d;

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through
        // this block leaves one unassigned and no latch is inferred.
        hi_d         = hi_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        checksum_d   = checksum_q;

        if (clear) begin
            hi_d       = 8'h00;
            checksum_d = 8'h00;
        end else if (byte_valid) begin
            if (load_hi) begin
                hi_d = byte_data;
            end
            if (load_lo) begin
                word_d       = {hi_q, byte_data};
                word_valid_d = 1'b1;
            end
            if (accumulate) begin
                checksum_d = checksum_q ^ byte_data;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q         <= 8'h00;
            word_q       <= 16'h0000;
            word_valid_q <= 1'b0;
            checksum_q   <= 8'h00;
        end else begin
            hi_q         <= hi_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            checksum_q   <= checksum_d;
        end
    end

    assign word_valid = word_valid_q;
    assign word       = word_q;
    assign checksum   = checksum_q;

endmodule

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//   Writer side of the instruction-cache download port. Consumes a framed byte
//   stream  SYNC, LEN_HI, LEN_LO, LEN x {INS_HI, INS_LO}, CHK  and writes each
//   big-endian instruction into the icache at consecutive indices starting at
//   0. CHK is the XOR of every byte after SYNC. The core is held while a frame
//   is loading and stays held if the frame fails.
//   Ports:
//     clk                system clock
//     rst                synchronous, active-high reset
//     start              1-cycle pulse, arms the loader (from IDLE/DONE/ERROR)
//     byte_valid         byte_data valid this cycle
//     byte_data          received byte
//     download_program   icache write enable, 1-cycle pulse per instruction
//     instruction_index  icache write address
//     instruction        icache write data
//     cpu_hold           core/icache hold, high from arming until DONE
//     busy               high while a frame is being consumed
//     done               frame loaded and checksum matched (until next start)
//     error              bad length or checksum mismatch (until next start)
// -----------------------------------------------------------------------------
module program_loader
    import program_loader_pkg::*;
#(
    parameter int         DEPTH     = DEFAULT_DEPTH,
    parameter int         ADDR_W    = DEFAULT_ADDR_W,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              download_program,
    output logic [ADDR_W-1:0] instruction_index,
    output logic [15:0]       instruction,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    loader_state_t     state_q,  state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [15:0]       len_q,    len_d;
    logic [ADDR_W-1:0] count_q,  count_d;

    logic        asm_clear;
    logic        asm_load_hi;
    logic        asm_load_lo;
    logic        asm_accumulate;
    logic        word_valid;
    logic [15:0] word;
    logic [7:0]  checksum;

    logic [15:0] len_w;
    logic [15:0] count_next_w;

    halfword_assembler u_assembler (
        .clk        (clk),
        .rst        (rst),
        .clear      (asm_clear),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .load_hi    (asm_load_hi),
        .load_lo    (asm_load_lo),
        .accumulate (asm_accumulate),
        .word_valid (word_valid),
        .word       (word),
        .checksum   (checksum)
    );

    // Length as it stands once the low length byte arrives.
    assign len_w = {len_hi_q, byte_data};

    // Number of writes that will have happened once the word whose low byte
    // is arriving now has been written. The previous word's pulse always
    // retires (and bumps count_q) before the next low byte can arrive.
    assign count_next_w = 16'(count_q) + 16'd1;

    always_comb begin
        state_d        = state_q;
        len_hi_d       = len_hi_q;
        len_d          = len_q;
        // The write address advances on the cycle after each write pulse.
        count_d        = count_q + {{(ADDR_W-1){1'b0}}, word_valid};
        asm_clear      = 1'b0;
        asm_load_hi    = 1'b0;
        asm_load_lo    = 1'b0;
        asm_accumulate = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                // start wins over a concurrent byte; bytes are ignored here.
                if (start) begin
                    asm_clear = 1'b1;
                    len_hi_d  = 8'h00;
                    len_d     = 16'h0000;
                    count_d   = '0;
                    state_d   = ST_SYNC;
                end
            end

            ST_SYNC: begin
                if (byte_valid && (byte_data == SYNC_BYTE)) begin
                    state_d = ST_LEN_HI;
                end
            end

            ST_LEN_HI: begin
                if (byte_valid) begin
                    len_hi_d       = byte_data;
                    asm_accumulate = 1'b1;
                    state_d        = ST_LEN_LO;
                end
            end

            ST_LEN_LO: begin
                if (byte_valid) begin
                    len_d          = len_w;
                    asm_accumulate = 1'b1;
                    if (len_w == 16'h0000) begin
                        state_d = ST_CHK;
                    end else if (len_w > DEPTH_W) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
            end

            ST_DATA_HI: begin
                if (byte_valid) begin
                    asm_load_hi    = 1'b1;
                    asm_accumulate = 1'b1;
                    state_d        = ST_DATA_LO;
                end
            end

            ST_DATA_LO: begin
                if (byte_valid) begin
                    asm_load_lo    = 1'b1;
                    asm_accumulate = 1'b1;
                    state_d        = (count_next_w == len_q) ? ST_CHK : ST_DATA_HI;
                end
            end

            ST_CHK: begin
                if (byte_valid) begin
                    state_d = (byte_data == checksum) ? ST_DONE : ST_ERROR;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            len_hi_q <= 8'h00;
            len_q    <= 16'h0000;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            count_q  <= count_d;
        end
    end

    assign download_program  = word_valid;
    assign instruction       = word;
    assign instruction_index = count_q;

    // Status is a pure function of the registered state: DONE and ERROR hold
    // until the next start, which makes done/error sticky, and ERROR keeps the
    // core held so a partial program never runs.
    assign busy     = !is_idle_like(state_q);
    assign cpu_hold = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done     = (state_q == ST_DONE);
    assign error    = (state_q == ST_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//   Directed bench for program_loader. Inputs change on the falling edge, the
//   DUT samples on the rising edge, and outputs are observed on the falling
//   edge. A monitor logs every write pulse (index, data) for later checks.
// -----------------------------------------------------------------------------
module tb_program_loader;

    localparam int LOG_N = 1100;

    logic        clk;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        download_program;
    logic [9:0]  instruction_index;
    logic [15:0] instruction;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [9:0]  log_idx [0:LOG_N-1];
    logic [15:0] log_dat [0:LOG_N-1];
    int          wr_n = 0;

    program_loader dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .byte_valid        (byte_valid),
        .byte_data         (byte_data),
        .download_program  (download_program),
        .instruction_index (instruction_index),
        .instruction       (instruction),
        .cpu_hold          (cpu_hold),
        .busy              (busy),
        .done              (done),
        .error             (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: a pulse wider than one cycle is logged more than once.
    always @(negedge clk) begin
        if (download_program === 1'b1) begin
            if (wr_n < LOG_N) begin
                log_idx[wr_n] = instruction_index;
                log_dat[wr_n] = instruction;
            end
            wr_n++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All stimulus tasks start and end just after a falling edge.
    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame1(input logic [7:0] chk);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(chk);
    endtask

    function automatic logic [15:0] t6_ins(input int i);
        return 16'(i * 37 + 16'h0123);
    endfunction

    initial begin
        int          base;
        int          bad;
        logic [7:0]  chk6;
        logic [15:0] w;

        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        idle(2);
        rst = 1'b0;
        idle(1);

        // Reset state
        check("rst_download", 32'(download_program), 32'd0);
        check("rst_index",    32'(instruction_index), 32'd0);
        check("rst_hold",     32'(cpu_hold), 32'd0);
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_done",     32'(done), 32'd0);
        check("rst_error",    32'(error), 32'd0);

        // Test 1: two-instruction frame, CHK = 0x42
        base = wr_n;
        pulse_start();
        check("t1_hold_armed", 32'(cpu_hold), 32'd1);
        check("t1_busy_armed", 32'(busy), 32'd1);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        check("t1_pulse0",     32'(download_program), 32'd1);
        check("t1_pulse0_dat", 32'(instruction), 32'h1234);
        check("t1_pulse0_idx", 32'(instruction_index), 32'd0);
        send_byte(8'hAB);
        check("t1_pulse0_width", 32'(download_program), 32'd0);
        send_byte(8'hCD);
        check("t1_pulse1",     32'(download_program), 32'd1);
        check("t1_pulse1_dat", 32'(instruction), 32'hABCD);
        check("t1_pulse1_idx", 32'(instruction_index), 32'd1);
        check("t1_hold_mid",   32'(cpu_hold), 32'd1);
        send_byte(8'h42);
        check("t1_pulse1_width", 32'(download_program), 32'd0);
        check("t1_done",  32'(done), 32'd1);
        check("t1_error", 32'(error), 32'd0);
        check("t1_hold",  32'(cpu_hold), 32'd0);
        check("t1_busy",  32'(busy), 32'd0);
        idle(3);
        check("t1_writes", 32'(wr_n - base), 32'd2);
        check("t1_done_sticky", 32'(done), 32'd1);

        // Test 2: leading junk discarded, zero-length frame
        base = wr_n;
        pulse_start();
        check("t2_done_cleared", 32'(done), 32'd0);
        send_byte(8'h00);
        send_byte(8'hFF);
        check("t2_busy_hunting", 32'(busy), 32'd1);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        check("t2_done", 32'(done), 32'd1);
        check("t2_hold", 32'(cpu_hold), 32'd0);
        idle(2);
        check("t2_writes", 32'(wr_n - base), 32'd0);

        // Test 3: LEN = 1001 rejected right after LEN_LO
        base = wr_n;
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'hE9);
        check("t3_error", 32'(error), 32'd1);
        check("t3_done",  32'(done), 32'd0);
        check("t3_hold",  32'(cpu_hold), 32'd1);
        check("t3_busy",  32'(busy), 32'd0);
        idle(3);
        check("t3_writes", 32'(wr_n - base), 32'd0);

        // Test 3b: LEN = 1000 accepted (boundary), then abandoned by reset
        pulse_start();
        check("t3b_error_cleared", 32'(error), 32'd0);
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'hE8);
        check("t3b_no_error", 32'(error), 32'd0);
        check("t3b_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;

        // Test 4: bad checksum, then recovery with a good frame
        base = wr_n;
        pulse_start();
        send_frame1(8'h43);
        check("t4_error", 32'(error), 32'd1);
        check("t4_done",  32'(done), 32'd0);
        check("t4_hold",  32'(cpu_hold), 32'd1);
        idle(2);
        check("t4_writes", 32'(wr_n - base), 32'd2);
        base = wr_n;
        pulse_start();
        check("t4_error_cleared", 32'(error), 32'd0);
        send_frame1(8'h42);
        check("t4_done2",  32'(done), 32'd1);
        check("t4_error2", 32'(error), 32'd0);
        idle(2);
        check("t4_writes2", 32'(wr_n - base), 32'd2);
        check("t4_idx0", 32'(log_idx[base]), 32'd0);
        check("t4_idx1", 32'(log_idx[base+1]), 32'd1);

        // Test 5: reset mid-frame, then full reload from index 0
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h12);
        rst = 1'b1;
        idle(1);
        check("t5_download", 32'(download_program), 32'd0);
        check("t5_index",    32'(instruction_index), 32'd0);
        check("t5_instr",    32'(instruction), 32'd0);
        check("t5_hold",     32'(cpu_hold), 32'd0);
        check("t5_busy",     32'(busy), 32'd0);
        check("t5_done",     32'(done), 32'd0);
        check("t5_error",    32'(error), 32'd0);
        rst = 1'b0;
        idle(1);
        base = wr_n;
        pulse_start();
        send_frame1(8'h42);
        check("t5_reload_done", 32'(done), 32'd1);
        idle(2);
        check("t5_writes", 32'(wr_n - base), 32'd2);
        check("t5_idx0", 32'(log_idx[base]), 32'd0);
        check("t5_dat0", 32'(log_dat[base]), 32'h1234);
        check("t5_idx1", 32'(log_idx[base+1]), 32'd1);
        check("t5_dat1", 32'(log_dat[base+1]), 32'hABCD);

        // Test 6: LEN = 1000, one byte every cycle
        chk6 = 8'h03 ^ 8'hE8;
        for (int i = 0; i < 1000; i++) begin
            w    = t6_ins(i);
            chk6 = chk6 ^ w[15:8] ^ w[7:0];
        end
        base = wr_n;
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'hE8);
        for (int i = 0; i < 1000; i++) begin
            w = t6_ins(i);
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
        send_byte(chk6);
        check("t6_done",  32'(done), 32'd1);
        check("t6_error", 32'(error), 32'd0);
        idle(3);
        check("t6_writes", 32'(wr_n - base), 32'd1000);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if ((base + i) < LOG_N) begin
                if ((log_idx[base+i] !== 10'(i)) || (log_dat[base+i] !== t6_ins(i))) begin
                    bad++;
                end
            end
        end
        check("t6_bad_entries", 32'(bad), 32'd0);
        check("t6_last_idx", 32'(log_idx[base+999]), 32'd999);
        check("t6_hold", 32'(cpu_hold), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
